axi_read: RTL and testbench
===========================

AXI_READ -- requirements
Module: axi_read

Interface
Parameters, one per line as name, default, meaning:
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, AXI and stream data width (64 to 1024, power of two).
REQ-003 The block SHALL have parameter AR_LEN, default 16, beats per burst (1 to 256); AR_LEN*DATA_WIDTH/8 SHALL divide 4096, so no burst crosses a 4 KB boundary.
REQ-004 The block SHALL have parameter BASE_ADDR, default 32'h1000_0000, start address of the first burst.

Ports, one per line as name, direction, width, meaning:
REQ-005 The block SHALL have port m_axi_aclk, in, 1, the single clock.
REQ-006 The block SHALL have port m_axi_areset, in, 1, reset (asynchronous, active-high).
REQ-007 The block SHALL have port rd_start, in, 1, single-cycle request to begin a transfer.
REQ-008 The block SHALL have port rd_bursts, in, 16, number of bursts, sampled with rd_start.
REQ-009 The block SHALL have port rd_busy, out, 1, high from an accepted rd_start until rd_done.
REQ-010 The block SHALL have port rd_done, out, 1, one-cycle pulse when the transfer completes.
REQ-011 The block SHALL have port rd_err, out, 1, sticky error flag, cleared by the next accepted rd_start.
REQ-012 The block SHALL have the AR ports m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_arready, with AXI4 widths.
REQ-013 The block SHALL have the R ports m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, m_axi_rready.
REQ-014 The block SHALL have the stream ports M_RD_tdata, out, DATA_WIDTH; M_RD_tvalid, out, 1; M_RD_tlast, out, 1; M_RD_tready, in, 1.

Function
REQ-015 The block SHALL drive the following constant AR fields: arid=0, arlen=AR_LEN-1, arsize=log2(DATA_WIDTH/8), arburst=INCR (01), arlock=0, arcache=3, arprot=0, arqos=0.
REQ-016 The FSM SHALL have the states IDLE, ADDR, DATA and DONE.
REQ-017 In IDLE, rd_start SHALL latch rd_bursts and set rd_busy. If rd_bursts=0 the FSM SHALL go to DONE; otherwise it SHALL go to ADDR.
REQ-018 In ADDR, the block SHALL hold arvalid=1 with araddr stable until arready is high in the same cycle; it SHALL then go to DATA.
REQ-019 In DATA, the block SHALL count accepted R beats (rvalid&rready). On the accepted beat with count AR_LEN-1, it SHALL decrement the remaining-burst counter and go to ADDR if bursts remain, else to DONE.
REQ-020 DONE SHALL last exactly 1 cycle: rd_done=1, rd_busy then falls, and the FSM returns to IDLE.
REQ-021 rd_start while rd_busy=1 SHALL be ignored.
REQ-022 Only one burst SHALL be outstanding at a time; there is no AR issue during DATA.
REQ-023 The address SHALL start at BASE_ADDR on each rd_start and advance by AR_LEN*DATA_WIDTH/8 after every AR handshake, wrapping modulo 2^ADDR_WIDTH.
REQ-024 rready SHALL be high only in DATA, and only when the output buffer can accept a beat; no beat SHALL be dropped or duplicated.
REQ-025 Each accepted beat SHALL appear on M_RD_tdata in order. M_RD_tlast SHALL be 1 on beat AR_LEN-1 of each burst, regardless of m_axi_rlast.
REQ-026 rd_err SHALL set if any accepted beat has rresp != 00, if rlast=1 on a beat other than AR_LEN-1, or if rlast=0 on beat AR_LEN-1. The transfer SHALL continue unchanged after an error.
REQ-027 Latency SHALL be as follows: arvalid rises the cycle after rd_start is accepted; a beat accepted on R SHALL be valid on M_RD the next cycle.
REQ-028 Full throughput SHALL be sustained: with M_RD_tready=1 and rvalid=1 continuously, one beat per cycle.
REQ-029 Backpressure on M_RD_tready SHALL propagate to rready within 1 cycle. M_RD_tvalid/tdata/tlast SHALL stay stable while tvalid=1 and tready=0.

Reset
REQ-030 m_axi_areset=1 SHALL asynchronously force: FSM=IDLE, arvalid=0, araddr=BASE_ADDR, rready=0, M_RD_tvalid=0, M_RD_tlast=0, M_RD_tdata=0, rd_busy=0, rd_done=0, rd_err=0, and all counters to 0.
REQ-031 Reset in the middle of a transfer SHALL abandon it and discard buffered beats; the block SHALL not complete the transfer after reset release.

Structure
REQ-032 The FSM state encodings and the AXI constants (BURST_INCR, CACHE_DEFAULT=3, RESP_OKAY) SHALL be placed in the shared package axi_pkg.
REQ-033 The output buffer SHALL be a 2-entry skid buffer in sub-module axis_skid_buf (parameter DATA_WIDTH+1 bits, carrying data and last). rready SHALL be taken from its registered s_ready.
REQ-034 A log2 helper function SHALL compute arsize from DATA_WIDTH.

Verification
REQ-035 With rd_start, rd_bursts=2, AR_LEN=16, DATA_WIDTH=64, slave always ready, tready=1: araddr SHALL be 0x1000_0000 then 0x1000_0080, 32 beats SHALL come out in order with tlast on beats 15 and 31, and rd_done SHALL pulse once.
REQ-036 With rd_bursts=0: there SHALL be no arvalid, rd_done SHALL pulse 2 cycles after rd_start, and rd_err=0.
REQ-037 With random M_RD_tready (50%) and random rvalid: the output SHALL match the slave data exactly with no loss or duplicates, and tdata SHALL be stable whenever tvalid=1 and tready=0.
REQ-038 With the slave returning rresp=10 on beat 5, or rlast early on beat 3: rd_err=1 until the next rd_start, and all 16 beats still delivered.
REQ-039 With reset asserted during beat 7 of burst 1: all outputs SHALL equal their reset values immediately, and a new rd_start SHALL restart at 0x1000_0000.
REQ-040 With rd_start pulsed during rd_busy: it SHALL be ignored, and the beat count and number of rd_done pulses SHALL be unchanged.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-master definitions: FSM state encoding, AXI4 field constants
// and the transfer-size helper.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  localparam logic [1:0]  BURST_INCR    = 2'b01;
  localparam logic [3:0]  CACHE_DEFAULT = 4'd3;
  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam int unsigned ID_WIDTH      = 4;

  // log2 of a power-of-two byte count, as an AXI size code (1..128 bytes)
  function automatic logic [2:0] log2_size(input int unsigned bytes);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) < bytes) r = r + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer between the AXI R channel and the output stream.
// s_ready is a register so upstream ready never depends on downstream ready.
module axis_skid_buf #(
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             s_ready_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i
);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;
  logic             sk_valid_q, sk_valid_d;
  logic [WIDTH-1:0] sk_data_q,  sk_data_d;
  logic             s_ready_q,  s_ready_d;
  logic             push;

  assign push = s_valid_i & s_ready_q;

  always_comb begin
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    if (!m_valid_q || m_ready_i) begin
      if (sk_valid_q) begin
        m_valid_d  = 1'b1;
        m_data_d   = sk_data_q;
        sk_valid_d = 1'b0;
      end else begin
        m_valid_d = push;
        if (push) m_data_d = s_data_i;
      end
    end else if (push) begin
      // output stalled: park the beat so nothing accepted is ever lost
      sk_valid_d = 1'b1;
      sk_data_d  = s_data_i;
    end
    s_ready_d = ~sk_valid_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      s_ready_q  <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;

endmodule

// File: rtl/axi_read.sv
// AXI4 read master: issues rd_bursts fixed-length INCR bursts from BASE_ADDR,
// one outstanding at a time, and forwards the beats onto an AXI-Stream port.
//
//   state | meaning
//   IDLE  | waiting for rd_start
//   ADDR  | arvalid held until arready
//   DATA  | collecting AR_LEN beats of the current burst
//   DONE  | one cycle; rd_done pulses on the following cycle
module axi_read
  import axi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           AR_LEN     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  rd_start,
  input  logic [15:0]           rd_bursts,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] M_RD_tdata,
  output logic                  M_RD_tvalid,
  output logic                  M_RD_tlast,
  input  logic                  M_RD_tready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(AR_LEN * DATA_WIDTH / 8);
  localparam logic [7:0]            LAST_BEAT = 8'(AR_LEN - 1);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           bursts_q, bursts_d;
  logic [7:0]            beat_q, beat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  skid_ready;
  logic                  beat_acc;
  logic                  is_last;
  logic [DATA_WIDTH:0]   skid_out;
  logic                  unused_rid;

  assign unused_rid   = ^m_axi_rid;
  assign m_axi_rready = skid_ready & (state_q == DATA);
  assign beat_acc     = m_axi_rvalid & m_axi_rready;
  assign is_last      = (beat_q == LAST_BEAT);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bursts_d = bursts_q;
    beat_d   = beat_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          busy_d   = 1'b1;
          err_d    = 1'b0;
          addr_d   = BASE_ADDR;
          bursts_d = rd_bursts;
          beat_d   = '0;
          state_d  = (rd_bursts == 16'd0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          addr_d  = addr_q + ADDR_STEP;
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat_acc) begin
          // framing comes from our own beat count; rlast is only cross-checked
          if ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != is_last)) err_d = 1'b1;
          if (is_last) begin
            beat_d   = '0;
            bursts_d = bursts_q - 16'd1;
            state_d  = (bursts_q == 16'd1) ? DONE : ADDR;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q  <= IDLE;
      addr_q   <= BASE_ADDR;
      bursts_q <= '0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bursts_q <= bursts_d;
      beat_q   <= beat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  axis_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i    (m_axi_aclk),
    .rst_i    (m_axi_areset),
    .s_valid_i(beat_acc),
    .s_data_i ({is_last, m_axi_rdata}),
    .s_ready_o(skid_ready),
    .m_valid_o(M_RD_tvalid),
    .m_data_o (skid_out),
    .m_ready_i(M_RD_tready)
  );

  assign M_RD_tdata = skid_out[DATA_WIDTH-1:0];
  assign M_RD_tlast = skid_out[DATA_WIDTH];

  assign rd_busy = busy_q;
  assign rd_done = done_q;
  assign rd_err  = err_q;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = LAST_BEAT;
  assign m_axi_arsize  = log2_size(DATA_WIDTH / 8);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;
  assign m_axi_arvalid = (state_q == ADDR);

endmodule

// File: tb/tb_axi_read.sv
// Randomized bench for axi_read: a reactive AXI slave plus a queue-based
// model of the expected stream, addresses, error flag and done timing.
module tb_axi_read;

  localparam int          LEN  = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] STEP = 32'd128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_start = 1'b0;
  logic [15:0] rd_bursts = '0;
  logic        rd_busy, rd_done, rd_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [63:0] tdata;
  logic        tvalid, tlast;
  logic        tready = 1'b0;

  always #5 clk = ~clk;

  axi_read dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .rd_start     (rd_start),
    .rd_bursts    (rd_bursts),
    .rd_busy      (rd_busy),
    .rd_done      (rd_done),
    .rd_err       (rd_err),
    .m_axi_arid   (arid),
    .m_axi_araddr (araddr),
    .m_axi_arlen  (arlen),
    .m_axi_arsize (arsize),
    .m_axi_arburst(arburst),
    .m_axi_arlock (arlock),
    .m_axi_arcache(arcache),
    .m_axi_arprot (arprot),
    .m_axi_arqos  (arqos),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rid    (rid),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rlast  (rlast),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready),
    .M_RD_tdata   (tdata),
    .M_RD_tvalid  (tvalid),
    .M_RD_tlast   (tlast),
    .M_RD_tready  (tready)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h, wanted %0h", tag, got, exp);
    end
  endtask

  // reference model state
  int          ar_pct = 100, rv_pct = 100, tr_pct = 100, err_mode = 0;
  int          tickno = 0;
  logic [64:0] exp_q[$];
  bit          s_act = 0, r_hold = 0;
  int          s_idx = 0, s_burst = 0, s_pend = 0;
  int          ar_out = 0, n_ar = 0, beats = 0, done_cnt = 0, done_tick = 0;
  bit          exp_err = 0;
  bit          p_tvalid = 0, p_tready = 0;
  logic [64:0] p_t = '0;

  // one clock: drive slave/sink at the falling edge, then account for the
  // handshakes that the next rising edge will complete
  task automatic tick();
    logic        ar_hs, r_hs, t_hs, lastb;
    logic [64:0] e;
    @(negedge clk);
    tickno++;
    if (!r_hold) begin
      if (!s_act && s_pend > 0) begin
        s_pend--;
        s_act = 1;
        s_idx = 0;
      end
      rvalid = s_act && ($urandom_range(99) < rv_pct);
      rdata  = {$urandom, $urandom};
      rresp  = (err_mode == 1 && s_burst == 0 && s_idx == 5) ? 2'b10 : 2'b00;
      rlast  = (s_idx == LEN - 1) || (err_mode == 2 && s_burst == 0 && s_idx == 3);
    end
    arready = ($urandom_range(99) < ar_pct);
    tready  = ($urandom_range(99) < tr_pct);

    if (p_tvalid && !p_tready) chk("t_stable", {tvalid, tlast, tdata}, {1'b1, p_t});

    ar_hs = arvalid & arready;
    r_hs  = rvalid & rready;
    t_hs  = tvalid & tready;

    if (arvalid) chk("one_outstanding", ar_out, 0);
    if (ar_hs) begin
      chk("araddr", araddr, 32'(BASE + STEP * n_ar));
      n_ar++;
      ar_out++;
      s_pend++;
    end
    if (r_hs) begin
      lastb = (s_idx == LEN - 1);
      exp_q.push_back({lastb, rdata});
      if (rresp != 2'b00 || rlast != lastb) exp_err = 1;
      s_idx++;
      beats++;
      if (s_idx == LEN) begin
        s_act = 0;
        s_burst++;
        ar_out--;
      end
      r_hold = 0;
    end else begin
      r_hold = rvalid;
    end
    if (t_hs) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("tdata", tdata, e[63:0]);
        chk("tlast", tlast, e[64]);
      end
    end
    if (rd_done) begin
      done_cnt++;
      done_tick = tickno;
    end
    p_tvalid = tvalid;
    p_tready = tready;
    p_t      = {tlast, tdata};
  endtask

  task automatic run_xfer(input int bursts, input int mode, input int stray_at, input bit chk_lat);
    int start_tick;
    bit fin;
    err_mode  = mode;
    n_ar      = 0;
    s_burst   = 0;
    exp_err   = 0;
    done_cnt  = 0;
    beats     = 0;
    rd_start  = 1'b1;
    rd_bursts = 16'(bursts);
    start_tick = tickno;
    tick();
    rd_start = 1'b0;
    chk("busy_after_start", rd_busy, 1);
    chk("err_cleared", rd_err, 0);
    fin = 0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      if (k == stray_at) begin
        rd_start  = 1'b1;
        rd_bursts = 16'd5;
      end else begin
        rd_start = 1'b0;
      end
      tick();
      fin = (done_cnt > 0);
    end
    rd_start = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
    if (chk_lat) chk("done_latency", done_tick - start_tick, 2 + 17 * bursts);
    for (int k = 0; k < 400 && exp_q.size() > 0; k++) tick();
    repeat (6) tick();
    chk("beats_in", beats, bursts * LEN);
    chk("beats_undelivered", exp_q.size(), 0);
    chk("done_pulses", done_cnt, 1);
    chk("rd_err", rd_err, exp_err);
    chk("busy_end", rd_busy, 0);
    chk("ar_count", n_ar, bursts);
  endtask

  task automatic chk_reset_vals();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, BASE);
    chk("rst_rready", rready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_done", rd_done, 0);
    chk("rst_err", rd_err, 0);
  endtask

  task automatic clear_model();
    s_act    = 0;
    s_pend   = 0;
    r_hold   = 0;
    rvalid   = 1'b0;
    exp_q.delete();
    ar_out   = 0;
    n_ar     = 0;
    p_tvalid = 0;
    beats    = 0;
    done_cnt = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals();
    chk("arid", arid, 0);
    chk("arlen", arlen, 15);
    chk("arsize", arsize, 3);
    chk("arburst", arburst, 1);
    chk("arlock", arlock, 0);
    chk("arcache", arcache, 3);
    chk("arprot", arprot, 0);
    chk("arqos", arqos, 0);
    rst = 1'b0;
    repeat (2) tick();

    // fully ready system: exact latency and one beat per cycle
    run_xfer(2, 0, -1, 1);
    run_xfer(0, 0, -1, 1);

    // random handshakes and backpressure
    ar_pct = 60;
    rv_pct = 60;
    tr_pct = 50;
    for (int i = 0; i < 4; i++) run_xfer(int'($urandom_range(4, 1)), 0, -1, 0);

    // error injection: SLVERR on beat 5, then early rlast on beat 3
    run_xfer(1, 1, -1, 0);
    repeat (5) tick();
    chk("err_sticky_resp", rd_err, 1);
    run_xfer(1, 2, -1, 0);
    repeat (5) tick();
    chk("err_sticky_rlast", rd_err, 1);
    run_xfer(2, 0, -1, 0);

    // rd_start while busy must be ignored
    run_xfer(2, 0, 10, 0);

    // reset during beat 7 of the first burst
    err_mode  = 0;
    n_ar      = 0;
    s_burst   = 0;
    exp_err   = 0;
    beats     = 0;
    done_cnt  = 0;
    rd_start  = 1'b1;
    rd_bursts = 16'd2;
    tick();
    rd_start = 1'b0;
    for (int k = 0; k < 2000 && beats < 7; k++) tick();
    chk("reached_beat7", beats, 7);
    #2 rst = 1'b1;
    clear_model();
    #1 chk_reset_vals();
    #1 rst = 1'b0;
    repeat (30) tick();
    chk("no_done_after_rst", done_cnt, 0);
    chk("no_beats_after_rst", beats, 0);
    chk("no_tvalid_after_rst", tvalid, 0);
    run_xfer(1, 0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
